// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types, widths and commit classifier for the commit-trace checker
package trace_pkg;

    localparam int TRACE_ENTRY_W = 55;

    typedef enum logic [2:0] {
        KIND_NOP   = 3'd0,
        KIND_REG   = 3'd1,
        KIND_LOAD  = 3'd2,
        KIND_STORE = 3'd3,
        KIND_HALT  = 3'd4
    } trace_kind_e;

    // Field order fixes the ROM image layout: kind occupies the top bits.
    // The destination register field cannot be called "reg" in SystemVerilog.
    typedef struct packed {
        trace_kind_e kind;
        logic [15:0] pc;
        logic [3:0]  dst_reg;
        logic [15:0] addr;
        logic [15:0] value;
    } trace_entry_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_KIND     = 3'd1,
        ERR_PC       = 3'd2,
        ERR_REG      = 3'd3,
        ERR_ADDR     = 3'd4,
        ERR_VALUE    = 3'd5,
        ERR_WATCHDOG = 3'd6,
        ERR_UNDERRUN = 3'd7
    } trace_err_e;

    // Halt wins over everything; a register write with a memory read is a load.
    function automatic trace_kind_e classify(input logic halt, input logic reg_we,
                                             input logic mem_re, input logic mem_we);
        if (halt)                 return KIND_HALT;
        else if (reg_we && mem_re) return KIND_LOAD;
        else if (reg_we)          return KIND_REG;
        else if (mem_we)          return KIND_STORE;
        else                      return KIND_NOP;
    endfunction

endpackage

// File: rtl/trace_prefetch_buf.sv
// rtl/trace_prefetch_buf.sv - two-entry expected-trace prefetch FIFO with in-flight ROM read tracking
module trace_prefetch_buf
    import trace_pkg::*;
#(
    parameter int DEPTH_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               consume,
    input  trace_entry_t       rd_data,
    output logic [DEPTH_W-1:0] rd_addr,
    output logic               rd_en,
    output trace_entry_t       head,
    output logic               empty,
    output logic               primed
);

    trace_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         inflight;
    logic         wrapped;
    logic         push;
    logic         pop;

    // A read issued last cycle returns now; an empty buffer never pops.
    assign push  = inflight;
    assign pop   = consume && (count != 2'd0);
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

    // Keep buffered + in-flight entries at two, counting this cycle's pop as free space.
    assign rd_en = !rst && fetch_en && !wrapped &&
                   (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    // Either both slots are spoken for, or the trace is exhausted and nothing more will arrive.
    assign primed = ((count + {1'b0, inflight}) == 2'd2) || (wrapped && !inflight);

    // Pointer, occupancy, in-flight and address bookkeeping; reset drops any pending return.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            inflight <= 1'b0;
            wrapped  <= 1'b0;
            rd_addr  <= '0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
                if (&rd_addr) wrapped <= 1'b1;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Entry storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rd_data;
    end

endmodule

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - in-order commit-stream checker against a ROM trace; TRACE_CHECK_LOAD_ADDR_EN adds the LOAD address compare
module trace_checker
    import trace_pkg::*;
#(
    parameter int DEPTH_W    = 10,
    parameter int MAX_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit_valid,
    input  logic [15:0]        commit_pc,
    input  logic               commit_reg_we,
    input  logic [3:0]         commit_reg,
    input  logic [15:0]        commit_reg_data,
    input  logic               commit_mem_re,
    input  logic               commit_mem_we,
    input  logic [15:0]        commit_mem_addr,
    input  logic [15:0]        commit_mem_data,
    input  logic               commit_halt,
    output logic [DEPTH_W-1:0] exp_addr,
    output logic               exp_rd,
    input  trace_entry_t       exp_entry,
    output logic               done,
    output logic               pass,
    output logic [2:0]         err_code,
    output logic [DEPTH_W-1:0] err_index,
    output logic [31:0]        inst_count,
    output logic [31:0]        cycle_count
);

`ifdef TRACE_CHECK_LOAD_ADDR_EN
    localparam bit LOAD_ADDR_CHK = 1'b1;
`else
    localparam bit LOAD_ADDR_CHK = 1'b0;
`endif

    localparam logic [31:0] WD_LAST = 32'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PREFETCH,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_e;

    state_e       state;
    logic         active;
    logic         consume;
    logic         empty;
    logic         primed;
    logic         watchdog;
    trace_entry_t head;
    trace_kind_e  commit_kind;
    trace_err_e   cmp_err;

    assign active   = (state == ST_PREFETCH) || (state == ST_RUN);
    assign consume  = active && commit_valid && !empty;
    assign watchdog = (state == ST_RUN) && (cycle_count == WD_LAST);

    trace_prefetch_buf #(.DEPTH_W(DEPTH_W)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .fetch_en (active),
        .consume  (consume),
        .rd_data  (exp_entry),
        .rd_addr  (exp_addr),
        .rd_en    (exp_rd),
        .head     (head),
        .empty    (empty),
        .primed   (primed)
    );

    // Classify the commit and find the highest-priority field that disagrees with the buffer head.
    always_comb begin
        cmp_err     = ERR_NONE;
        commit_kind = classify(commit_halt, commit_reg_we, commit_mem_re, commit_mem_we);
        if (commit_kind != head.kind) begin
            cmp_err = ERR_KIND;
        end else if (commit_pc != head.pc) begin
            cmp_err = ERR_PC;
        end else if ((commit_kind == KIND_REG || commit_kind == KIND_LOAD) &&
                     commit_reg != head.dst_reg) begin
            cmp_err = ERR_REG;
        end else if ((commit_kind == KIND_STORE || (commit_kind == KIND_LOAD && LOAD_ADDR_CHK)) &&
                     commit_mem_addr != head.addr) begin
            cmp_err = ERR_ADDR;
        end else if (((commit_kind == KIND_REG || commit_kind == KIND_LOAD) &&
                      commit_reg_data != head.value) ||
                     (commit_kind == KIND_STORE && commit_mem_data != head.value)) begin
            cmp_err = ERR_VALUE;
        end
    end

    // Checker FSM with registered verdict and counters; PASS and FAIL hold everything until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_PREFETCH;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_code    <= ERR_NONE;
            err_index   <= '0;
            inst_count  <= '0;
            cycle_count <= '0;
        end else if (active) begin
            if (state == ST_RUN) cycle_count <= cycle_count + 1'b1;
            if (consume)         inst_count  <= inst_count + 1'b1;

            if (commit_valid && empty) begin
                state     <= ST_FAIL;
                done      <= 1'b1;
                err_code  <= ERR_UNDERRUN;
                err_index <= inst_count[DEPTH_W-1:0];
            end else if (consume && cmp_err != ERR_NONE) begin
                state     <= ST_FAIL;
                done      <= 1'b1;
                err_code  <= cmp_err;
                err_index <= inst_count[DEPTH_W-1:0];
            end else if (consume && commit_kind == KIND_HALT) begin
                state <= ST_PASS;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else if (watchdog) begin
                state     <= ST_FAIL;
                done      <= 1'b1;
                err_code  <= ERR_WATCHDOG;
                err_index <= inst_count[DEPTH_W-1:0];
            end else if (state == ST_PREFETCH && primed) begin
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - directed table-driven and sequence bench for trace_checker
module tb_trace_checker;
    import trace_pkg::*;

    localparam int DEPTH_W = 3;
    localparam int MAX_CYC = 50;
    localparam int NVEC    = 19;

`ifdef TRACE_CHECK_LOAD_ADDR_EN
    localparam logic [2:0] LA_CODE = 3'd4;
    localparam logic       LA_DONE = 1'b1;
`else
    localparam logic [2:0] LA_CODE = 3'd0;
    localparam logic       LA_DONE = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] pc;
        logic        reg_we;
        logic [3:0]  rd;
        logic [15:0] reg_data;
        logic        mem_re;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;
        logic        halt;
    } commit_t;

    typedef struct packed {
        trace_entry_t e;
        commit_t      c;
        logic [2:0]   code;
        logic         dn;
        logic         ps;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               commit_valid = 1'b0;
    logic [15:0]        commit_pc = '0;
    logic               commit_reg_we = 1'b0;
    logic [3:0]         commit_reg = '0;
    logic [15:0]        commit_reg_data = '0;
    logic               commit_mem_re = 1'b0;
    logic               commit_mem_we = 1'b0;
    logic [15:0]        commit_mem_addr = '0;
    logic [15:0]        commit_mem_data = '0;
    logic               commit_halt = 1'b0;
    logic [DEPTH_W-1:0] exp_addr;
    logic               exp_rd;
    trace_entry_t       exp_entry = '0;
    logic               done;
    logic               pass;
    logic [2:0]         err_code;
    logic [DEPTH_W-1:0] err_index;
    logic [31:0]        inst_count;
    logic [31:0]        cycle_count;

    trace_entry_t rom [8];
    vec_t         vecs [NVEC];
    int           checks = 0;
    int           errors = 0;

    trace_checker #(.DEPTH_W(DEPTH_W), .MAX_CYCLES(MAX_CYC)) dut (
        .clk             (clk),
        .rst             (rst),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_reg_we   (commit_reg_we),
        .commit_reg      (commit_reg),
        .commit_reg_data (commit_reg_data),
        .commit_mem_re   (commit_mem_re),
        .commit_mem_we   (commit_mem_we),
        .commit_mem_addr (commit_mem_addr),
        .commit_mem_data (commit_mem_data),
        .commit_halt     (commit_halt),
        .exp_addr        (exp_addr),
        .exp_rd          (exp_rd),
        .exp_entry       (exp_entry),
        .done            (done),
        .pass            (pass),
        .err_code        (err_code),
        .err_index       (err_index),
        .inst_count      (inst_count),
        .cycle_count     (cycle_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after exp_rd.
    always @(posedge clk) if (exp_rd) exp_entry <= rom[exp_addr];

    function automatic trace_entry_t ent(trace_kind_e k, logic [15:0] pc, logic [3:0] r,
                                         logic [15:0] a, logic [15:0] v);
        trace_entry_t t;
        t.kind = k; t.pc = pc; t.dst_reg = r; t.addr = a; t.value = v;
        return t;
    endfunction

    function automatic commit_t c_nop(logic [15:0] pc);
        commit_t c = '0;
        c.pc = pc;
        return c;
    endfunction

    function automatic commit_t c_reg(logic [15:0] pc, logic [3:0] r, logic [15:0] d);
        commit_t c = c_nop(pc);
        c.reg_we = 1'b1; c.rd = r; c.reg_data = d;
        return c;
    endfunction

    function automatic commit_t c_load(logic [15:0] pc, logic [3:0] r, logic [15:0] a, logic [15:0] d);
        commit_t c = c_reg(pc, r, d);
        c.mem_re = 1'b1; c.mem_addr = a;
        return c;
    endfunction

    function automatic commit_t c_store(logic [15:0] pc, logic [15:0] a, logic [15:0] d);
        commit_t c = c_nop(pc);
        c.mem_we = 1'b1; c.mem_addr = a; c.mem_data = d;
        return c;
    endfunction

    function automatic commit_t c_halt(logic [15:0] pc);
        commit_t c = c_nop(pc);
        c.halt = 1'b1;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one commit for exactly one rising edge.
    task automatic put(input commit_t c);
        commit_valid    = 1'b1;
        commit_pc       = c.pc;
        commit_reg_we   = c.reg_we;
        commit_reg      = c.rd;
        commit_reg_data = c.reg_data;
        commit_mem_re   = c.mem_re;
        commit_mem_we   = c.mem_we;
        commit_mem_addr = c.mem_addr;
        commit_mem_data = c.mem_data;
        commit_halt     = c.halt;
        @(posedge clk); #1;
        commit_valid    = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = ent(KIND_HALT, 16'hFFFE, 4'd0, 16'd0, 16'd0);
    endtask

    // Leaves the bench in cycle 0, the first cycle with rst low.
    task automatic do_reset();
        rst = 1'b1; commit_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic to_run();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_pass"},  32'(pass), 32'd0);
        chk({tag, "_code"},  32'(err_code), 32'd0);
        chk({tag, "_index"}, 32'(err_index), 32'd0);
        chk({tag, "_inst"},  inst_count, 32'd0);
        chk({tag, "_cyc"},   cycle_count, 32'd0);
        chk({tag, "_rd"},    32'(exp_rd), 32'd0);
        chk({tag, "_addr"},  32'(exp_addr), 32'd0);
    endtask

    task automatic load_match_rom();
        clear_rom();
        rom[0] = ent(KIND_REG,   16'h0000, 4'd1, 16'h0000, 16'h0005);
        rom[1] = ent(KIND_STORE, 16'h0002, 4'd0, 16'h0010, 16'h0005);
        rom[2] = ent(KIND_HALT,  16'h0004, 4'd0, 16'h0000, 16'h0000);
    endtask

    task automatic match_run(input string tag);
        put(c_reg(16'h0000, 4'd1, 16'h0005));
        put(c_store(16'h0002, 16'h0010, 16'h0005));
        @(negedge clk);
        chk({tag, "_done_before_halt"}, 32'(done), 32'd0);
        put(c_halt(16'h0004));
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_pass"}, 32'(pass), 32'd1);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
        chk({tag, "_inst"}, inst_count, 32'd3);
        chk({tag, "_cyc"},  cycle_count, 32'd3);
    endtask

    initial begin
        commit_t tmp;
        int      n;

        // Single-commit vectors: rom[0] is the expected entry, commit arrives in cycle 3.
        vecs[0]  = '{ent(KIND_REG, 16'h0100, 4'd1, 16'h0, 16'h0005), c_reg(16'h0100, 4'd1, 16'h0005), 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{ent(KIND_REG, 16'h0100, 4'd1, 16'h0, 16'h0005), c_reg(16'h0102, 4'd1, 16'h0005), 3'd2, 1'b1, 1'b0};
        vecs[2]  = '{ent(KIND_REG, 16'h0100, 4'd1, 16'h0, 16'h0005), c_reg(16'h0100, 4'd2, 16'h0005), 3'd3, 1'b1, 1'b0};
        vecs[3]  = '{ent(KIND_REG, 16'h0100, 4'd1, 16'h0, 16'h0005), c_reg(16'h0100, 4'd1, 16'h0006), 3'd5, 1'b1, 1'b0};
        vecs[4]  = '{ent(KIND_REG, 16'h0100, 4'd1, 16'h0, 16'h0005), c_reg(16'h0100, 4'd2, 16'h0006), 3'd3, 1'b1, 1'b0};
        vecs[5]  = '{ent(KIND_STORE, 16'h0200, 4'd0, 16'h0010, 16'h00AA), c_store(16'h0200, 16'h0010, 16'h00AA), 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{ent(KIND_STORE, 16'h0200, 4'd0, 16'h0010, 16'h00AA), c_store(16'h0200, 16'h0011, 16'h00AA), 3'd4, 1'b1, 1'b0};
        vecs[7]  = '{ent(KIND_STORE, 16'h0200, 4'd0, 16'h0010, 16'h00AA), c_store(16'h0200, 16'h0010, 16'h00AB), 3'd5, 1'b1, 1'b0};
        vecs[8]  = '{ent(KIND_STORE, 16'h0200, 4'd0, 16'h0010, 16'h00AA), c_reg(16'h0200, 4'd1, 16'h00AA), 3'd1, 1'b1, 1'b0};
        vecs[9]  = '{ent(KIND_STORE, 16'h0200, 4'd0, 16'h0010, 16'h00AA), c_nop(16'h0300), 3'd1, 1'b1, 1'b0};
        vecs[10] = '{ent(KIND_NOP, 16'h0040, 4'd0, 16'h0, 16'h0), c_nop(16'h0040), 3'd0, 1'b0, 1'b0};
        vecs[11] = '{ent(KIND_NOP, 16'h0040, 4'd0, 16'h0, 16'h0), c_nop(16'h0042), 3'd2, 1'b1, 1'b0};
        vecs[12] = '{ent(KIND_HALT, 16'h0044, 4'd0, 16'h0, 16'h0), c_halt(16'h0044), 3'd0, 1'b1, 1'b1};
        vecs[13] = '{ent(KIND_LOAD, 16'h0050, 4'd3, 16'h0020, 16'h0077), c_load(16'h0050, 4'd3, 16'h0020, 16'h0077), 3'd0, 1'b0, 1'b0};
        vecs[14] = '{ent(KIND_LOAD, 16'h0050, 4'd3, 16'h0020, 16'h0077), c_load(16'h0050, 4'd3, 16'h0024, 16'h0077), LA_CODE, LA_DONE, 1'b0};
        vecs[15] = '{ent(KIND_LOAD, 16'h0050, 4'd3, 16'h0020, 16'h0077), c_load(16'h0050, 4'd3, 16'h0020, 16'h0078), 3'd5, 1'b1, 1'b0};
        vecs[16] = '{ent(KIND_STORE, 16'h0200, 4'd5, 16'h0010, 16'h00AA), c_store(16'h0200, 16'h0010, 16'h00AA), 3'd0, 1'b0, 1'b0};
        tmp = c_reg(16'h0044, 4'd1, 16'h0005);
        tmp.halt = 1'b1;
        vecs[17] = '{ent(KIND_HALT, 16'h0044, 4'd0, 16'h0, 16'h0), tmp, 3'd0, 1'b1, 1'b1};
        vecs[18] = '{ent(KIND_REG, 16'h0050, 4'd3, 16'h0, 16'h0077), c_load(16'h0050, 4'd3, 16'h0020, 16'h0077), 3'd1, 1'b1, 1'b0};

        // Reset state and prefetch timing, then the matching run.
        load_match_rom();
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("pf_c0_rd", 32'(exp_rd), 32'd1);
        chk("pf_c0_addr", 32'(exp_addr), 32'd0);
        @(negedge clk);
        chk("pf_c1_rd", 32'(exp_rd), 32'd1);
        chk("pf_c1_addr", 32'(exp_addr), 32'd1);
        @(negedge clk);
        chk("pf_c2_rd", 32'(exp_rd), 32'd0);
        @(posedge clk); #1;
        match_run("match");
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("match_hold_cyc", cycle_count, 32'd3);
        chk("match_hold_inst", inst_count, 32'd3);
        chk("match_hold_pass", 32'(pass), 32'd1);

        // Table-driven single-commit checks.
        for (int v = 0; v < NVEC; v++) begin
            clear_rom();
            rom[0] = vecs[v].e;
            do_reset();
            to_run();
            put(vecs[v].c);
            @(negedge clk);
            chk($sformatf("vec%0d_code", v), 32'(err_code), 32'(vecs[v].code));
            chk($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].dn));
            chk($sformatf("vec%0d_pass", v), 32'(pass), 32'(vecs[v].ps));
            chk($sformatf("vec%0d_inst", v), inst_count, 32'd1);
        end

        // Value mismatch at trace index 5.
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = ent(KIND_REG, 16'(2 * i), 4'd1, 16'h0, 16'(i));
        rom[5] = ent(KIND_REG, 16'h000A, 4'd2, 16'h0, 16'h1234);
        do_reset();
        to_run();
        for (int i = 0; i < 5; i++) put(c_reg(16'(2 * i), 4'd1, 16'(i)));
        put(c_reg(16'h000A, 4'd2, 16'h1235));
        @(negedge clk);
        chk("val5_code", 32'(err_code), 32'd5);
        chk("val5_index", 32'(err_index), 32'd5);
        chk("val5_pass", 32'(pass), 32'd0);
        chk("val5_inst", inst_count, 32'd6);

        // Kind mismatch, then a correct HALT must not change the verdict.
        clear_rom();
        rom[0] = ent(KIND_STORE, 16'h0000, 4'd0, 16'h0010, 16'h0007);
        rom[1] = ent(KIND_HALT,  16'h0002, 4'd0, 16'h0, 16'h0);
        do_reset();
        to_run();
        put(c_reg(16'h0000, 4'd1, 16'h0007));
        put(c_halt(16'h0002));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("kind_hold_code", 32'(err_code), 32'd1);
        chk("kind_hold_pass", 32'(pass), 32'd0);
        chk("kind_hold_inst", inst_count, 32'd1);
        chk("kind_hold_done", 32'(done), 32'd1);

        // Watchdog with no commits, bounded wait for done.
        clear_rom();
        do_reset();
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wd_done", 32'(done), 32'd1);
        chk("wd_latency", 32'(n), 32'd53);
        chk("wd_code", 32'(err_code), 32'd6);
        chk("wd_cyc", cycle_count, 32'd50);
        chk("wd_pass", 32'(pass), 32'd0);

        // Underrun: commit in cycle 1 while the buffer is still empty.
        load_match_rom();
        do_reset();
        @(posedge clk); #1;
        put(c_reg(16'h0000, 4'd1, 16'h0005));
        @(negedge clk);
        chk("under_code", 32'(err_code), 32'd7);
        chk("under_done", 32'(done), 32'd1);
        chk("under_inst", inst_count, 32'd0);

        // Reset mid-RUN zeroes outputs; a fresh run then passes.
        load_match_rom();
        do_reset();
        to_run();
        put(c_reg(16'h0000, 4'd1, 16'h0005));
        @(negedge clk);
        chk("midrst_inst_before", inst_count, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        to_run();
        match_run("rerun");

        // Address wrap: eight NOPs fill the trace, the ninth commit underruns.
        clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = ent(KIND_NOP, 16'(2 * i), 4'd0, 16'h0, 16'h0);
        do_reset();
        to_run();
        for (int i = 0; i < 8; i++) put(c_nop(16'(2 * i)));
        @(negedge clk);
        chk("wrap_done_before", 32'(done), 32'd0);
        chk("wrap_rd_stopped", 32'(exp_rd), 32'd0);
        chk("wrap_inst_before", inst_count, 32'd8);
        put(c_nop(16'h0010));
        @(negedge clk);
        chk("wrap_code", 32'(err_code), 32'd7);
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_inst", inst_count, 32'd8);
        chk("wrap_index", 32'(err_index), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
